// File: rtl/sq_pkg.sv
// Shared widths, sweep bounds and FSM encoding for the RAM squaring sweep.
package sq_pkg;

  localparam int unsigned SqAddrW    = 4;
  localparam int unsigned SqDataW    = 8;
  localparam int unsigned SqRootW    = 4;
  localparam int unsigned SqLastAddr = 15;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StLoad  = 3'd2,
    StCalc  = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } sq_state_e;

endpackage

// File: rtl/sq_odd_accum.sv
// Iterative squarer: r*r built by summing the first r odd numbers, one per step.
module sq_odd_accum
  import sq_pkg::*;
#(
  parameter int unsigned DATA_W = SqDataW,
  parameter int unsigned ROOT_W = SqRootW
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              load,
  input  logic              step,
  input  logic [ROOT_W-1:0] root,
  output logic              zero,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] odd_q, odd_d;
  logic [ROOT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    odd_d = odd_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = '0;
      odd_d = DATA_W'(1);
      cnt_d = root;
    end else if (step && (cnt_q != '0)) begin
      acc_d = acc_q + odd_q;
      odd_d = odd_q + DATA_W'(2);
      cnt_d = cnt_q - ROOT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      acc_q <= '0;
      odd_q <= DATA_W'(1);
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      odd_q <= odd_d;
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
  assign acc  = acc_q;

endmodule

// File: rtl/sq_ram_sweep.sv
// Sweeps a synchronous RAM, replacing each word's low-nibble root with its square.
module sq_ram_sweep
  import sq_pkg::*;
#(
  parameter int unsigned ADDR_W    = SqAddrW,
  parameter int unsigned DATA_W    = SqDataW,
  parameter int unsigned ROOT_W    = SqRootW,
  parameter int unsigned LAST_ADDR = SqLastAddr
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              St,
  input  logic [DATA_W-1:0] MDO,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] MDI,
  output logic              Write_Enable,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Sq
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

  sq_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mdi_q, mdi_d;
  logic [DATA_W-1:0] sq_q, sq_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              acc_load, acc_step, acc_zero;
  logic [DATA_W-1:0] acc;

  // Only the root nibble of each word matters; the upper bits are discarded.
  logic unused_mdo_hi;
  assign unused_mdo_hi = ^MDO[DATA_W-1:ROOT_W];

  sq_odd_accum #(
    .DATA_W(DATA_W),
    .ROOT_W(ROOT_W)
  ) u_accum (
    .CLK   (CLK),
    .ResetN(ResetN),
    .load  (acc_load),
    .step  (acc_step),
    .root  (MDO[ROOT_W-1:0]),
    .zero  (acc_zero),
    .acc   (acc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mdi_d    = mdi_q;
    sq_d     = sq_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    acc_load = 1'b0;
    acc_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (St) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = StRead;
        end
      end
      StRead: state_d = StLoad;
      StLoad: begin
        acc_load = 1'b1;
        state_d  = StCalc;
      end
      StCalc: begin
        if (!acc_zero) begin
          acc_step = 1'b1;
        end else begin
          mdi_d   = acc;
          sq_d    = acc;
          we_d    = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (addr_q == LastAddr) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StRead;
        end
      end
      StDone: begin
        // Waiting for St to drop prevents a held start from re-triggering a sweep.
        if (!St) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mdi_q   <= '0;
      sq_q    <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mdi_q   <= mdi_d;
      sq_q    <= sq_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Addr         = addr_q;
  assign MDI          = mdi_q;
  assign Sq           = sq_q;
  assign Write_Enable = we_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_sq_ram_sweep.sv
// Self-checking bench for sq_ram_sweep with a registered-read RAM model and square reference.
module tb_sq_ram_sweep;

  logic       CLK    = 1'b0;
  logic       ResetN = 1'b0;
  logic       St     = 1'b0;
  logic [7:0] MDO;
  logic [3:0] Addr;
  logic [7:0] MDI;
  logic       Write_Enable;
  logic       Busy;
  logic       Done;
  logic [7:0] Sq;

  logic [7:0] mem     [16];
  logic [7:0] pre_img [16];
  logic       pre_go = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] wr_addr[$];
  logic [7:0] wr_data[$];
  logic [7:0] wr_sq[$];
  int         double_we = 0;
  logic       prev_we   = 1'b0;

  always #5 CLK = ~CLK;

  sq_ram_sweep dut (
    .CLK         (CLK),
    .ResetN      (ResetN),
    .St          (St),
    .MDO         (MDO),
    .Addr        (Addr),
    .MDI         (MDI),
    .Write_Enable(Write_Enable),
    .Busy        (Busy),
    .Done        (Done),
    .Sq          (Sq)
  );

  // RAM: registered read, a write is visible on the same-cycle read.
  always @(posedge CLK) begin
    if (pre_go) begin
      for (int i = 0; i < 16; i++) mem[i] <= pre_img[i];
    end else if (Write_Enable) begin
      mem[Addr] <= MDI;
    end
    MDO <= Write_Enable ? MDI : mem[Addr];
  end

  always @(negedge CLK) begin
    if (Write_Enable) begin
      wr_addr.push_back(Addr);
      wr_data.push_back(MDI);
      wr_sq.push_back(Sq);
    end
    if (Write_Enable && prev_we) double_we++;
    prev_we = Write_Enable;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] sq_model(input logic [7:0] w);
    int r;
    r = int'(w[3:0]);
    return 8'(r * r);
  endfunction

  function automatic int root_sum();
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(pre_img[i][3:0]);
    return s;
  endfunction

  task automatic preload();
    @(negedge CLK);
    pre_go = 1'b1;
    @(negedge CLK);
    pre_go = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_sq.delete();
    double_we = 0;
  endtask

  // Caller raises St at a negedge first. lat = cycles from Busy rise to Done rise;
  // we_lat = cycles from Busy rise to first Write_Enable.
  task automatic run_sweep(input bit hold, input bit toggle, output int lat, output int we_lat,
                           output bit ok);
    int c_busy;
    int c_we;
    c_busy = -1;
    c_we   = -1;
    ok     = 1'b0;
    lat    = -1;
    we_lat = -1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if (Busy && c_busy < 0) c_busy = c;
      if (Write_Enable && c_we < 0) c_we = c;
      if (Done) begin
        ok     = 1'b1;
        lat    = c - c_busy;
        we_lat = c_we - c_busy;
        break;
      end
      if (toggle && c_busy >= 0) St = 1'($urandom_range(0, 1));
      else if (!hold && !toggle && c == 1) St = 1'b0;
    end
    if (!hold) St = 1'b0;
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    St     = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++; if (Addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %0h want 0", Addr); end
    n_checks++; if (MDI !== 8'd0) begin n_fail++; $display("FAIL reset_mdi got %0h want 0", MDI); end
    n_checks++; if (Write_Enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", Write_Enable); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_checks++; if (Sq !== 8'd0) begin n_fail++; $display("FAIL reset_sq got %0h want 0", Sq); end
    ResetN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_ramp();
    int lat, we_lat, bad;
    bit ok;
    for (int i = 0; i < 16; i++) pre_img[i] = 8'(i);
    preload();
    St = 1'b1;
    run_sweep(1'b0, 1'b0, lat, we_lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ramp_timeout got no Done want Done"); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== 8'(i * i)) begin
        n_fail++; $display("FAIL ramp_word[%0d] got %0d want %0d", i, mem[i], i * i);
      end
    end
    n_checks++; if (wr_addr.size() != 16) begin n_fail++; $display("FAIL ramp_we_count got %0d want 16", wr_addr.size()); end
    bad = 0;
    foreach (wr_addr[k]) if (wr_addr[k] !== 4'(k)) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ramp_addr_order got %0d out of order want 0", bad); end
    n_checks++; if (double_we != 0) begin n_fail++; $display("FAIL ramp_we_width got %0d multi-cycle want 0", double_we); end
    n_checks++; if (lat != 64 + 120) begin n_fail++; $display("FAIL ramp_latency got %0d want 184", lat); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_zero_and_hold();
    int lat, we_lat, bad, n_before;
    bit ok;
    for (int i = 0; i < 16; i++) pre_img[i] = 8'h00;
    preload();
    St = 1'b1;
    run_sweep(1'b1, 1'b0, lat, we_lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_timeout got no Done want Done"); end
    n_checks++; if (lat != 64) begin n_fail++; $display("FAIL zero_latency got %0d want 64", lat); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 8'h00) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL zero_words got %0d nonzero want 0", bad); end
    n_checks++; if (Sq !== 8'h00) begin n_fail++; $display("FAIL zero_sq got %0h want 0", Sq); end
    n_before = wr_addr.size();
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (Done !== 1'b1 || Busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_done got %0d bad cycles want 0", bad); end
    n_checks++; if (wr_addr.size() != n_before) begin n_fail++; $display("FAIL hold_no_restart got %0d writes want %0d", wr_addr.size(), n_before); end
    St = 1'b0;
    @(negedge CLK);
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL hold_release_done got %b want 0", Done); end
    repeat (3) @(negedge CLK);
    n_checks++; if (Busy !== 1'b0 || wr_addr.size() != n_before) begin n_fail++; $display("FAIL hold_idle got busy=%b writes=%0d want busy=0 writes=%0d", Busy, wr_addr.size(), n_before); end
  endtask

  task automatic test_upper_nibble();
    int lat, we_lat;
    bit ok;
    for (int i = 0; i < 16; i++) pre_img[i] = 8'h00;
    pre_img[0] = 8'hF3;
    preload();
    St = 1'b1;
    run_sweep(1'b0, 1'b0, lat, we_lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nibble_timeout got no Done want Done"); end
    n_checks++; if (mem[0] !== 8'h09) begin n_fail++; $display("FAIL nibble_word0 got %0h want 09", mem[0]); end
    n_checks++; if (wr_sq.size() == 0 || wr_sq[0] !== 8'h09) begin n_fail++; $display("FAIL nibble_sq got %0h want 09", (wr_sq.size() == 0) ? 8'hxx : wr_sq[0]); end
    n_checks++; if (wr_data.size() == 0 || wr_data[0] !== 8'h09) begin n_fail++; $display("FAIL nibble_mdi got %0h want 09", (wr_data.size() == 0) ? 8'hxx : wr_data[0]); end
    // Busy is seen in word 0's first cycle, Write_Enable in its seventh.
    n_checks++; if (we_lat != 6) begin n_fail++; $display("FAIL nibble_word0_cycles got %0d want 7", we_lat + 1); end
    n_checks++; if (lat != 67) begin n_fail++; $display("FAIL nibble_latency got %0d want 67", lat); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_toggle_random();
    int lat, we_lat, bad, exp_lat;
    bit ok;
    logic [7:0] exp_img [16];
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 16; i++) begin
        pre_img[i] = 8'($urandom);
        exp_img[i] = sq_model(pre_img[i]);
      end
      exp_lat = 64 + root_sum();
      preload();
      St = 1'b1;
      run_sweep(1'b0, 1'b1, lat, we_lat, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL toggle_timeout[%0d] got no Done want Done", it); end
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== exp_img[i]) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL toggle_words[%0d] got %0d wrong want 0", it, bad); end
      bad = 0;
      foreach (wr_addr[k]) if (wr_addr[k] !== 4'(k)) bad++;
      n_checks++; if (bad != 0 || wr_addr.size() != 16) begin n_fail++; $display("FAIL toggle_addr[%0d] got %0d writes %0d misordered want 16 and 0", it, wr_addr.size(), bad); end
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL toggle_latency[%0d] got %0d want %0d", it, lat, exp_lat); end
      St = 1'b0;
      repeat (3) @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid();
    int lat, we_lat, bad;
    bit ok, found;
    logic [7:0] exp_img [16];
    for (int i = 0; i < 16; i++) pre_img[i] = 8'($urandom);
    pre_img[5] = {pre_img[5][7:4], 4'(4 + $urandom_range(0, 11))};
    preload();
    St = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if (c == 1) St = 1'b0;
      if (Busy && Addr == 4'd5) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_reach_word5 got not reached want reached"); end
    repeat (2) @(negedge CLK);
    #1 ResetN = 1'b0;
    #1;
    n_checks++; if (Addr !== 4'd0 || MDI !== 8'd0 || Sq !== 8'd0) begin n_fail++; $display("FAIL mid_reset_data got addr=%0h mdi=%0h sq=%0h want 0 0 0", Addr, MDI, Sq); end
    n_checks++; if (Write_Enable !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl got we=%b busy=%b done=%b want 0 0 0", Write_Enable, Busy, Done); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      exp_img[i] = (i < 5) ? sq_model(pre_img[i]) : pre_img[i];
      if (mem[i] !== exp_img[i]) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_partial_words got %0d wrong want 0", bad); end
    n_checks++; if (wr_addr.size() != 5) begin n_fail++; $display("FAIL mid_write_count got %0d want 5", wr_addr.size()); end
    @(negedge CLK);
    ResetN = 1'b1;
    for (int i = 0; i < 16; i++) pre_img[i] = exp_img[i];
    preload();
    for (int i = 0; i < 16; i++) exp_img[i] = sq_model(pre_img[i]);
    St = 1'b1;
    run_sweep(1'b0, 1'b0, lat, we_lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_restart_timeout got no Done want Done"); end
    n_checks++; if (wr_addr.size() == 0 || wr_addr[0] !== 4'd0) begin n_fail++; $display("FAIL mid_restart_addr got %0h want 0", (wr_addr.size() == 0) ? 4'hx : wr_addr[0]); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== exp_img[i]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_restart_words got %0d wrong want 0", bad); end
    n_checks++; if (lat != 64 + root_sum()) begin n_fail++; $display("FAIL mid_restart_latency got %0d want %0d", lat, 64 + root_sum()); end
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_zero_and_hold();
    test_upper_nibble();
    test_toggle_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
